cntb_seq: RTL and testbench
===========================

# cntb_seq

Parametrised, multi-cycle successor to the single-cycle 32-bit run counter in the custom-instruction unit. Given a WIDTH-bit word, a start index and a direction, it counts how many consecutive bits beyond the index equal the bit at the index. It scans CHUNK bits per cycle behind valid/ready handshakes on input and output. It sits in the core's custom execution path, where a wider word or a tighter timing budget rules out the flat combinational tree.

## Interface
- WIDTH, 32: word width; power of two, 2..64
- CHUNK, 8: bits examined per BUSY cycle; 1..WIDTH
- IDXW, $clog2(WIDTH): index and count width (derived; do not override)

- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous assert, active low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  block can accept a request (high only in IDLE)
- word_i  in  WIDTH  word to scan
- index_i  in  IDXW  start bit position
- dir_i  in  1  0 = scan toward bit 0; 1 = scan toward bit WIDTH-1
- flush_i  in  1  synchronous abort; returns to IDLE, drops any result
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- count_o  out  IDXW  run length beyond index, excluding the index bit
- end_o  out  1  run reached the word boundary with no mismatch
- busy_o  out  1  high in BUSY

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: in_ready_o=1, out_valid_o=0, count_o=0, end_o=0, busy_o=0. Internal word, index, position and accumulator registers are cleared.
- IDLE: on in_valid_i && in_ready_o, the block latches word_i, index_i and dir_i. It also latches ref = word_i[index_i] and pos = index. It clears the accumulator and moves to BUSY.
- BUSY, each cycle:
  - Examine the next n = min(CHUNK, remaining) bits beyond pos in the latched direction.
  - remaining = index for dir=0, and WIDTH-1-index for dir=1.
  - Add to the accumulator the number of leading bits equal to ref.
  - On a mismatch inside the chunk: go to DONE with end=0.
  - Otherwise advance pos by n. When remaining reaches 0, go to DONE with end=1.
- BUSY with remaining=0 at entry (index=0 with dir=0, or index=WIDTH-1 with dir=1): one BUSY cycle, count=0, end=1.
- DONE: out_valid_o=1. count_o and end_o are stable and held until out_ready_i is sampled high. The block then returns to IDLE.
- Inputs are ignored outside IDLE; word_i may change freely once accepted.
- Counting is polarity-agnostic: ref=1 counts ones and ref=0 counts zeros.
- Maximum count is WIDTH-1, which fits IDXW bits with no saturation.
- flush_i has priority over every transition. The next state is IDLE, out_valid_o drops on the following edge, and no result is produced. flush_i in IDLE also blocks acceptance in that cycle.
- Async reset mid-operation: all outputs take their reset values immediately, and no result is produced.

## Timing
- Acceptance edge A. Let k = number of chunks scanned: k = 1 if remaining=0; otherwise k = ceil(scanned_bits/CHUNK), truncated at the first mismatch.
- out_valid_o rises at edge A+k. in_ready_o rises on the edge after the out_valid_o && out_ready_i handshake.
- Minimum period between accepted requests is k+2 cycles when out_ready_i is held high.
- Worst case is WIDTH=32, CHUNK=8, full run: k=4.
- count_o and end_o are registered outputs, with no combinational path from any input.
- in_ready_o depends only on state, with no combinational path from in_valid_i.

## Test plan
- Case 1: WIDTH=32, CHUNK=8, word=0x0000000E, index=3, dir=0 -> count_o=2, end_o=0, out_valid_o at A+1.
- Case 2: word=0xFFFFFFFF, index=31, dir=0 -> count_o=31, end_o=1, out_valid_o at A+4. Repeat with dir=1, index=0 -> same result.
- Case 3: word=0x00000002, index=5, dir=0, zero run -> count_o=3, end_o=0. index=0, dir=0 -> count_o=0, end_o=1 at A+1.
- Case 4: dir=1, word=0x000000F0, index=4 -> count_o=3, end_o=0. Hold out_ready_i low 5 cycles -> outputs stable and in_ready_o stays 0.
- Case 5: assert flush_i at A+2 of a 4-chunk scan -> no out_valid_o, in_ready_o=1 at A+3. A fresh request then completes correctly.
- Case 6: drop rst_ni mid-BUSY -> outputs take reset values immediately. Random regression with CHUNK in {1,3,8,32} and WIDTH in {8,32,64} against a reference model, including back-to-back requests with out_ready_i tied high.

Source files
------------

// File: rtl/cntb_seq_if.sv
// Request/result bundle for the chunked bit-run counter.
interface cntb_seq_if #(
   parameter int WIDTH = 32,
   parameter int IDXW  = $clog2(WIDTH)
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] word_i;
   logic [IDXW-1:0]  index_i;
   logic             dir_i;
   logic             flush_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [IDXW-1:0]  count_o;
   logic             end_o;
   logic             busy_o;

   modport master (
      output in_valid_i, word_i, index_i, dir_i,
      output flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, count_o,
      input  end_o, busy_o
   );

   modport slave (
      input  in_valid_i, word_i, index_i, dir_i,
      input  flush_i, out_ready_i,
      output in_ready_o, out_valid_o, count_o,
      output end_o, busy_o
   );
endinterface

// File: rtl/cntb_seq.sv
// Multi-cycle run counter: scans CHUNK bits per cycle from a start index
// and reports how many following bits match the start bit.
module cntb_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   localparam int IDXW = $clog2(WIDTH)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   cntb_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] word_q;
   logic             ref_q;
   logic             dir_q;
   logic [IDXW-1:0]  pos_q;
   logic [IDXW-1:0]  rem_q;
   logic [IDXW-1:0]  acc_q;
   logic [IDXW-1:0]  count_q;
   logic             end_q;
   logic             valid_q;
   logic             ready_q;
   logic             busy_q;

   logic [IDXW-1:0]  hits;
   logic [IDXW-1:0]  bit_idx;
   logic [IDXW-1:0]  step;
   logic [IDXW-1:0]  rem_nx;
   logic [IDXW-1:0]  acc_nx;
   logic             miss;

   // Leading matches in this chunk; lanes past the word edge are masked.
   always_comb begin
      hits    = '0;
      miss    = 1'b0;
      bit_idx = '0;
      for (int i = 0; i < CHUNK; i++) begin
         bit_idx = dir_q ? pos_q + IDXW'(i + 1)
                         : pos_q - IDXW'(i + 1);
         if (!miss && (IDXW'(i) < rem_q)) begin
            if (word_q[bit_idx] == ref_q)
               hits = hits + IDXW'(1);
            else
               miss = 1'b1;
         end
      end
   end

   assign step = ({1'b0, rem_q} < (IDXW+1)'(CHUNK))
               ? rem_q : IDXW'(CHUNK);
   assign rem_nx = rem_q - step;
   assign acc_nx = acc_q + hits;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         word_q  <= '0;
         ref_q   <= 1'b0;
         dir_q   <= 1'b0;
         pos_q   <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
         count_q <= '0;
         end_q   <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else if (bus.flush_i) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid_i) begin
                  word_q  <= bus.word_i;
                  ref_q   <= bus.word_i[bus.index_i];
                  dir_q   <= bus.dir_i;
                  pos_q   <= bus.index_i;
                  rem_q   <= bus.dir_i
                           ? IDXW'(WIDTH - 1) - bus.index_i
                           : bus.index_i;
                  acc_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               acc_q <= acc_nx;
               if (miss || rem_nx == '0) begin
                  count_q <= acc_nx;
                  end_q   <= !miss;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  pos_q <= dir_q ? pos_q + step : pos_q - step;
                  rem_q <= rem_nx;
               end
            end
            DONE: begin
               if (bus.out_ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready_o  = ready_q;
   assign bus.out_valid_o = valid_q;
   assign bus.count_o     = count_q;
   assign bus.end_o       = end_q;
   assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_cntb_seq.sv
// Directed and randomized checks of cntb_seq over several WIDTH/CHUNK mixes.
module tb_cntb_seq;

   localparam int W  = 32;
   localparam int C  = 8;
   localparam int IW = $clog2(W);
   localparam int NG = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rst_g = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   done_cnt = 0;
   bit   tie = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   cntb_seq_if #(.WIDTH(W)) bus();

   cntb_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   // Reference: walk outward bit by bit until a mismatch or the edge.
   function automatic void model(
      input  logic [63:0] w,
      input  int width, input int chunk,
      input  int idx, input bit d,
      output int cnt, output bit e, output int k);
      int rem, p, scanned;
      bit r;
      r = w[idx];
      cnt = 0;
      e = 1'b1;
      rem = d ? width - 1 - idx : idx;
      for (int j = 1; j <= rem; j++) begin
         p = d ? idx + j : idx - j;
         if (w[p] != r) begin
            e = 1'b0;
            break;
         end
         cnt++;
      end
      scanned = e ? rem : cnt + 1;
      k = (rem == 0) ? 1 : (scanned + chunk - 1) / chunk;
   endfunction

   function automatic logic [63:0] rnd_word();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0: ;
         1: w = $urandom_range(0, 1) ? '1 : '0;
         2: w = w & {$urandom, $urandom} & {$urandom, $urandom};
         default: w = ~(w & {$urandom, $urandom}
                          & {$urandom, $urandom});
      endcase
      return w;
   endfunction

   task automatic start(input logic [W-1:0] w,
                        input int idx, input bit d);
      int t;
      t = 0;
      while (bus.in_ready_o !== 1'b1 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("ready_before_req", bus.in_ready_o, 1);
      bus.in_valid_i = 1'b1;
      bus.word_i     = w;
      bus.index_i    = IW'(idx);
      bus.dir_i      = d;
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      bus.in_valid_i = 1'b0;
      bus.word_i     = $urandom;
      bus.index_i    = IW'($urandom_range(0, W - 1));
      bus.dir_i      = $urandom_range(0, 1);
   endtask

   task automatic finish_req(input int ecnt, input bit eend,
                             input int ek, input int hold,
                             input string tag);
      int lat;
      lat = 0;
      bus.out_ready_i = tie;
      while (bus.out_valid_o !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, ek);
      chk({tag, "_cnt"}, bus.count_o, ecnt);
      chk({tag, "_end"}, bus.end_o, eend);
      chk({tag, "_rdy_lo"}, bus.in_ready_o, 0);
      repeat (hold) begin
         @(posedge clk); #1;
         chk({tag, "_hold_v"}, bus.out_valid_o, 1);
         chk({tag, "_hold_c"}, bus.count_o, ecnt);
         chk({tag, "_hold_e"}, bus.end_o, eend);
         chk({tag, "_hold_r"}, bus.in_ready_o, 0);
      end
      bus.out_ready_i = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_rdy_hi"}, bus.in_ready_o, 1);
      chk({tag, "_v_lo"}, bus.out_valid_o, 0);
      bus.out_ready_i = tie;
   endtask

   task automatic run(input logic [W-1:0] w, input int idx,
                      input bit d, input int ecnt, input bit eend,
                      input int ek, input int hold,
                      input string tag);
      start(w, idx, d);
      finish_req(ecnt, eend, ek, hold, tag);
   endtask

   // Extra configurations, each exercised by its own random stream.
   for (genvar g = 0; g < NG; g++) begin : g_cfg
      localparam int GW = (g < 3) ? 8 : (g < 5) ? 32 : 64;
      localparam int GC = (g == 0) ? 1 : (g == 1) ? 3 :
                          (g == 2) ? 8 : (g == 3) ? 3 :
                          (g == 4) ? 32 : (g == 5) ? 1 : 32;
      localparam int GI = $clog2(GW);

      cntb_seq_if #(.WIDTH(GW)) b();

      cntb_seq #(.WIDTH(GW), .CHUNK(GC)) u (
         .clk_i  (clk),
         .rst_ni (rst_g),
         .bus    (b)
      );

      initial begin
         logic [63:0] w;
         int idx, cnt, k, lat, t;
         bit d, e;
         b.in_valid_i  = 1'b0;
         b.flush_i     = 1'b0;
         b.out_ready_i = 1'b1;
         b.word_i      = '0;
         b.index_i     = '0;
         b.dir_i       = 1'b0;
         wait (rst_g === 1'b1);
         @(posedge clk); #1;
         for (int n = 0; n < 40; n++) begin
            w   = rnd_word();
            idx = $urandom_range(0, GW - 1);
            d   = $urandom_range(0, 1);
            model(w, GW, GC, idx, d, cnt, e, k);
            b.out_ready_i = ($urandom_range(0, 3) != 0);
            t = 0;
            while (b.in_ready_o !== 1'b1 && t < 100) begin
               @(posedge clk); #1;
               t++;
            end
            chk($sformatf("g%0d_rdy", g), b.in_ready_o, 1);
            b.in_valid_i = 1'b1;
            b.word_i     = w[GW-1:0];
            b.index_i    = GI'(idx);
            b.dir_i      = d;
            @(posedge clk); #1;
            b.in_valid_i = 1'b0;
            b.word_i     = GW'({$urandom, $urandom});
            lat = 0;
            while (b.out_valid_o !== 1'b1 && lat < 200) begin
               @(posedge clk); #1;
               lat++;
            end
            chk($sformatf("g%0d_lat", g), lat, k);
            chk($sformatf("g%0d_cnt", g), b.count_o, cnt);
            chk($sformatf("g%0d_end", g), b.end_o, e);
            if (!b.out_ready_i) begin
               repeat ($urandom_range(1, 3)) begin
                  @(posedge clk); #1;
                  chk($sformatf("g%0d_hold", g),
                      {b.out_valid_o, b.count_o},
                      {1'b1, GI'(cnt)});
               end
               b.out_ready_i = 1'b1;
            end
            @(posedge clk); #1;
            chk($sformatf("g%0d_ret", g),
                {b.in_ready_o, b.out_valid_o}, 2'b10);
         end
         done_cnt++;
      end
   end

   initial begin
      logic [63:0] w;
      int idx, cnt, k, prev_acc, prev_k, t;
      bit d, e;
      bus.in_valid_i  = 1'b0;
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b0;
      bus.word_i      = '0;
      bus.index_i     = '0;
      bus.dir_i       = 1'b0;

      #12;
      chk("rst_ready", bus.in_ready_o, 1);
      chk("rst_valid", bus.out_valid_o, 0);
      chk("rst_count", bus.count_o, 0);
      chk("rst_end", bus.end_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      rst_n = 1'b1;
      rst_g = 1'b1;
      @(posedge clk); #1;

      run(32'h0000000E, 3, 1'b0, 2, 1'b0, 1, 0, "c1");
      run(32'hFFFFFFFF, 31, 1'b0, 31, 1'b1, 4, 0, "c2a");
      run(32'hFFFFFFFF, 0, 1'b1, 31, 1'b1, 4, 0, "c2b");
      run(32'h00000002, 5, 1'b0, 3, 1'b0, 1, 0, "c3a");
      run(32'h00000002, 0, 1'b0, 0, 1'b1, 1, 0, "c3b");
      run(32'h000000F0, 4, 1'b1, 3, 1'b0, 1, 5, "c4");
      run(32'h00000000, 0, 1'b1, 31, 1'b1, 4, 0, "zeros");
      run(32'h12345678, 31, 1'b1, 0, 1'b1, 1, 0, "top_up");
      run(32'h000003FF, 0, 1'b1, 9, 1'b0, 2, 0, "chunk2");

      // Flush in the middle of a four-chunk scan.
      start(32'hFFFFFFFF, 31, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      chk("flush_ready", bus.in_ready_o, 1);
      chk("flush_busy", bus.busy_o, 0);
      repeat (6) begin
         @(posedge clk); #1;
         chk("flush_no_valid", bus.out_valid_o, 0);
      end
      run(32'hFFFF0000, 20, 1'b1, 11, 1'b1, 2, 0, "post_flush");

      bus.in_valid_i = 1'b1;
      bus.flush_i    = 1'b1;
      bus.word_i     = 32'hFFFFFFFF;
      bus.index_i    = IW'(31);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      bus.flush_i    = 1'b0;
      chk("idle_flush_busy", bus.busy_o, 0);
      chk("idle_flush_ready", bus.in_ready_o, 1);

      // Asynchronous reset while busy.
      start(32'hFFFFFFFF, 31, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_busy", bus.busy_o, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_ready", bus.in_ready_o, 1);
      chk("arst_valid", bus.out_valid_o, 0);
      chk("arst_count", bus.count_o, 0);
      chk("arst_end", bus.end_o, 0);
      chk("arst_busy", bus.busy_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         chk("arst_no_valid", bus.out_valid_o, 0);
      end
      run(32'h0000FF00, 12, 1'b0, 4, 1'b0, 1, 0, "post_rst");

      // Back-to-back random requests with the consumer always ready.
      tie = 1'b1;
      prev_acc = 0;
      prev_k = 0;
      for (int n = 0; n < 60; n++) begin
         w   = rnd_word();
         idx = $urandom_range(0, W - 1);
         d   = $urandom_range(0, 1);
         model(w, W, C, idx, d, cnt, e, k);
         start(w[W-1:0], idx, d);
         if (n > 0)
            chk("b2b_period", acc_cyc - prev_acc, prev_k + 2);
         prev_acc = acc_cyc;
         prev_k = k;
         finish_req(cnt, e, k, 0, "rnd");
      end

      t = 0;
      while (done_cnt < NG && t < 40000) begin
         @(posedge clk);
         t++;
      end
      chk("gen_done", done_cnt, NG);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
